fht_reorder_loader: RTL

FHT_REORDER_LOADER -- requirements
Module: fht_reorder_loader

---
 rtl/fht_reorder_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fht_reorder_loader.sv
// FHT input reorder loader.
// Walks an index j over 2^A_BIT source addresses, in linear or bit-reversed
// order. For each index it reads all BANKS source words at once through a
// shared read address, then writes them one bank per cycle to the
// destination at address j. Every output is driven straight from a flop.
module fht_reorder_loader #(
   parameter int D_BIT  = 16,
   parameter int A_BIT  = 8,
   parameter int BANKS  = 4,
   parameter int RD_LAT = 1
) (
   input  logic                     iCLK,
   input  logic                     iRESET,
   input  logic                     iSTART,
   input  logic                     iMODE,
   input  logic                     iABORT,
   output logic [A_BIT-1:0]         oADDR_RD,
   input  logic [BANKS*D_BIT-1:0]   iDATA_RD,
   output logic [D_BIT-1:0]         oDATA_WR,
   output logic [A_BIT-1:0]         oADDR_WR,
   output logic [BANKS-1:0]         oWE,
   output logic                     oBUSY,
   output logic                     oRDY
);

   // Bank-select counter width; a single bank still needs one bit.
   localparam int KW = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam logic [KW-1:0]  K_LAST  = KW'(BANKS - 1);
   localparam logic [1:0]     RD_LAST = 2'(RD_LAT);
   // j has one spare bit, so the last index is compared without any wrap.
   localparam logic [A_BIT:0] J_LAST  = {1'b0, {A_BIT{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q,   state_d;
   logic [A_BIT:0]         j_q,       j_d;
   logic                   mode_q,    mode_d;
   logic [1:0]             rd_cnt_q,  rd_cnt_d;
   logic [KW-1:0]          k_q,       k_d;
   logic [BANKS*D_BIT-1:0] cap_q,     cap_d;
   logic [A_BIT-1:0]       addr_rd_q, addr_rd_d;
   logic [A_BIT-1:0]       addr_wr_q, addr_wr_d;
   logic [D_BIT-1:0]       data_wr_q, data_wr_d;
   logic [BANKS-1:0]       we_q,      we_d;
   logic                   busy_q,    busy_d;
   logic                   rdy_q,     rdy_d;

   logic [A_BIT:0]         j_inc_s;
   logic [KW-1:0]          k_inc_s;

   // Mirror an address: bit i trades places with bit A_BIT-1-i.
   function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] v);
      logic [A_BIT-1:0] r;
      for (int i = 0; i < A_BIT; i++) begin
         r[i] = v[A_BIT-1-i];
      end
      return r;
   endfunction

   // Source address for index j under the latched ordering mode.
   function automatic logic [A_BIT-1:0] rd_addr(input logic m, input logic [A_BIT-1:0] j);
      return m ? bitrev(j) : j;
   endfunction

   // Strobe pattern that selects only bank k.
   function automatic logic [BANKS-1:0] one_hot(input logic [KW-1:0] k);
      logic [BANKS-1:0] r;
      r = '0;
      for (int b = 0; b < BANKS; b++) begin
         r[b] = (k == KW'(b));
      end
      return r;
   endfunction

   // Bank k's word from a packed multi-bank vector.
   function automatic logic [D_BIT-1:0] word_sel(input logic [BANKS*D_BIT-1:0] v,
                                                 input logic [KW-1:0]          k);
      logic [D_BIT-1:0] w;
      w = '0;
      for (int b = 0; b < BANKS; b++) begin
         w = (k == KW'(b)) ? v[b*D_BIT +: D_BIT] : w;
      end
      return w;
   endfunction

   assign j_inc_s = j_q + (A_BIT+1)'(1);
   assign k_inc_s = k_q + KW'(1);

   // Sequencer: next state and next value of every registered output.
   always_comb begin
      state_d   = state_q;
      j_d       = j_q;
      mode_d    = mode_q;
      rd_cnt_d  = rd_cnt_q;
      k_d       = k_q;
      cap_d     = cap_q;
      addr_rd_d = addr_rd_q;
      addr_wr_d = addr_wr_q;
      data_wr_d = data_wr_q;
      we_d      = '0;
      rdy_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // An abort while idle changes nothing; only start matters here.
            if (iSTART) begin
               state_d   = S_READ;
               mode_d    = iMODE;
               j_d       = '0;
               rd_cnt_d  = 2'd0;
               addr_rd_d = '0;   // index 0 maps to address 0 in both orders
            end else begin
               state_d   = S_IDLE;
            end
         end

         S_READ: begin
            if (iABORT) begin
               state_d = S_IDLE;
            end else if (rd_cnt_q == RD_LAST) begin
               // Read data for the held address is valid now; capture it
               // and present bank 0 in the first write cycle.
               state_d   = S_WRITE;
               cap_d     = iDATA_RD;
               k_d       = '0;
               we_d      = one_hot(KW'(0));
               addr_wr_d = j_q[A_BIT-1:0];
               data_wr_d = iDATA_RD[D_BIT-1:0];
            end else begin
               rd_cnt_d  = rd_cnt_q + 2'd1;
            end
         end

         S_WRITE: begin
            if (iABORT) begin
               state_d = S_IDLE;
            end else if (k_q == K_LAST) begin
               if (j_q == J_LAST) begin
                  state_d = S_DONE;
                  rdy_d   = 1'b1;
               end else begin
                  state_d   = S_READ;
                  j_d       = j_inc_s;
                  rd_cnt_d  = 2'd0;
                  addr_rd_d = rd_addr(mode_q, j_inc_s[A_BIT-1:0]);
               end
            end else begin
               k_d       = k_inc_s;
               we_d      = one_hot(k_inc_s);
               data_wr_d = word_sel(cap_q, k_inc_s);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q   <= S_IDLE;
         j_q       <= '0;
         mode_q    <= 1'b0;
         rd_cnt_q  <= 2'd0;
         k_q       <= '0;
         cap_q     <= '0;
         addr_rd_q <= '0;
         addr_wr_q <= '0;
         data_wr_q <= '0;
         we_q      <= '0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         j_q       <= j_d;
         mode_q    <= mode_d;
         rd_cnt_q  <= rd_cnt_d;
         k_q       <= k_d;
         cap_q     <= cap_d;
         addr_rd_q <= addr_rd_d;
         addr_wr_q <= addr_wr_d;
         data_wr_q <= data_wr_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         rdy_q     <= rdy_d;
      end
   end

   assign oADDR_RD = addr_rd_q;
   assign oADDR_WR = addr_wr_q;
   assign oDATA_WR = data_wr_q;
   assign oWE      = we_q;
   assign oBUSY    = busy_q;
   assign oRDY     = rdy_q;

endmodule
